// File: rtl/drw_tx_arbiter.sv
// drw_tx_arbiter: round-robin scheduler that shares one dual-rail RTZ 4-phase output channel between NREQ requesters.
// Latency: codeword on rails one cycle after selection; transfer >= 1 + 2*SYNC_STAGES + 1 cycles with an immediate ack.
// Backpressure: req is held until done; a new transfer starts only after the previous one has returned to spacer and ack_s is low.
//
// Ports:
//   clk, reset       - clock (rising edge), synchronous active-high reset
//   req, req_data    - per-requester request level and word (requester i at [i*WIDTH +: WIDTH])
//   done             - one-cycle completion pulse for the served requester
//   busy             - high whenever a transfer is in flight (state != IDLE)
//   ch_t, ch_f       - true/false rails, straight from flops
//   ch_ack           - asynchronous channel acknowledge (high = codeword consumed, low = spacer consumed)
//   err              - sticky handshake watchdog flag
//
// Optional build macro: DRW_TX_TIMEOUT_EN enables the per-phase watchdog that drives err;
// without it err is tied low and no counter is built.

module drw_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [WIDTH-1:0]        ch_t,
  output logic [WIDTH-1:0]        ch_f,
  input  logic                    ch_ack,
  output logic                    err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Elaboration-time parameter sanity checks.
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("drw_tx_arbiter: NREQ must be in 2..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("drw_tx_arbiter: SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("drw_tx_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_NULL = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q,   ptr_d;
  logic [PW-1:0]          win_q,   win_d;
  logic [WIDTH-1:0]       ch_t_q,  ch_t_d;
  logic [WIDTH-1:0]       ch_f_q,  ch_f_d;
  logic [NREQ-1:0]        done_q,  done_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  // Round-robin search results.
  logic                   found;
  logic [PW-1:0]          win_idx;
  logic [PW:0]            sel_sum;
  logic [WIDTH-1:0]       sel_word;

  // ---------------------------------------------------------------------------
  // ch_ack synchronizer. Reset loads ones so that IDLE treats the channel as
  // not-yet-released until a real low ack has propagated through the chain;
  // this keeps a channel that is still high from an aborted transfer from
  // being handed a fresh codeword.
  // ---------------------------------------------------------------------------
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Round-robin pick: first asserted req at or after ptr_q, wrapping mod NREQ.
  // ---------------------------------------------------------------------------
  always_comb begin
    found   = 1'b0;
    win_idx = ptr_q;
    sel_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sel_sum >= (PW+1)'(NREQ)) begin
        sel_sum = sel_sum - (PW+1)'(NREQ);
      end
      if (!found && req[sel_sum[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = sel_sum[PW-1:0];
      end
    end
  end

  assign sel_word = req_data[int'(win_idx)*WIDTH +: WIDTH];

  // ---------------------------------------------------------------------------
  // Next-state / output logic. Rails only ever move between a full codeword
  // and the all-zero spacer, each in a single edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    ch_t_d  = ch_t_q;
    ch_f_d  = ch_f_q;
    done_d  = '0;

    case (state_q)
      ST_IDLE: begin
        // Selection is held off during the done cycle so the requester just
        // served gets one cycle to drop or renew its req before it is seen.
        if (!ack_s && (done_q == '0) && found) begin
          win_d   = win_idx;
          ch_t_d  = sel_word;
          ch_f_d  = ~sel_word;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (ack_s) begin
          ch_t_d  = '0;
          ch_f_d  = '0;
          state_d = ST_NULL;
        end
      end

      ST_NULL: begin
        if (!ack_s) begin
          done_d  = NREQ'(1) << win_q;
          if (win_q == PW'(NREQ-1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_q + 1'b1;
          end
          state_d = ST_IDLE;
        end
      end

      default: begin
        ch_t_d  = '0;
        ch_f_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      ch_t_q     <= '0;
      ch_f_q     <= '0;
      done_q     <= '0;
      ack_sync_q <= '1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      ch_t_q     <= ch_t_d;
      ch_f_q     <= ch_f_d;
      done_q     <= done_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ch_ack};
    end
  end

  assign ch_t = ch_t_q;
  assign ch_f = ch_f_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Handshake watchdog. The counter restarts on every state change and counts
  // cycles spent waiting in DATA or NULL. Hitting the limit only flags err;
  // the FSM keeps waiting so the channel never sees a premature transition.
  // ---------------------------------------------------------------------------
`ifdef DRW_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q,    err_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if ((state_q != ST_IDLE) && (to_cnt_q != TW'(TIMEOUT_CYCLES))) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    if (to_cnt_d == TW'(TIMEOUT_CYCLES)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_drw_tx_arbiter.sv
// tb_drw_tx_arbiter: directed and randomized-ack bench for drw_tx_arbiter (NREQ=4, WIDTH=8, SYNC_STAGES=2).
// Latency: n/a (testbench).
// Backpressure: an ack responder process models the dual-rail receiver with configurable delay.

module tb_drw_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int SS    = 2;
  localparam int TO    = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      ch_t;
  logic [WIDTH-1:0]      ch_f;
  logic                  ch_ack;
  logic                  err;

  always #5 clk = ~clk;

  drw_tx_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .done(done), .busy(busy), .ch_t(ch_t), .ch_f(ch_f),
    .ch_ack(ch_ack), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_full(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
    return ((t ^ f) == '1) && ((t & f) == '0);
  endfunction

  function automatic bit is_spacer(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
    return (t == '0) && (f == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Ack responder: manual level, or an automatic receiver with a delay of
  // ack_dly cycles per phase (random 0..20 when ack_rnd is set).
  // ---------------------------------------------------------------------------
  bit               ack_auto = 1'b0;
  bit               ack_rnd  = 1'b0;
  logic             ack_man  = 1'b0;
  int               ack_wait = 0;
  int               ack_dly  = 0;
  logic [WIDTH-1:0] rx_word  = '0;

  initial begin
    ch_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!ack_auto) begin
        ch_ack   = ack_man;
        ack_wait = 0;
      end else if (!ch_ack && is_full(ch_t, ch_f)) begin
        if (ack_wait >= ack_dly) begin
          ch_ack   = 1'b1;
          rx_word  = ch_t;
          ack_wait = 0;
          ack_dly  = ack_rnd ? int'($urandom_range(0, 20)) : 0;
        end else begin
          ack_wait++;
        end
      end else if (ch_ack && is_spacer(ch_t, ch_f)) begin
        if (ack_wait >= ack_dly) begin
          ch_ack   = 1'b0;
          ack_wait = 0;
          ack_dly  = ack_rnd ? int'($urandom_range(0, 20)) : 0;
        end else begin
          ack_wait++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rail integrity and done one-hot monitor.
  // ---------------------------------------------------------------------------
  bit               chk_en    = 1'b0;
  int               rail_viol = 0;
  int               done_viol = 0;
  bit               prev_full = 1'b0;
  logic [WIDTH-1:0] prev_t    = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if ((ch_t & ch_f) != '0) rail_viol++;
        if (!is_full(ch_t, ch_f) && !is_spacer(ch_t, ch_f)) rail_viol++;
        if (is_full(ch_t, ch_f) && prev_full && (ch_t != prev_t)) rail_viol++;
        if ($countones(done) > 1) done_viol++;
        prev_t    = ch_t;
        prev_full = is_full(ch_t, ch_f);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_codeword(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (is_full(ch_t, ch_f)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output logic [NREQ-1:0] d);
    d = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done != '0) begin
        d = done;
        break;
      end
    end
  endtask

  logic [WIDTH-1:0] dat [NREQ];

  initial begin
    bit               ok;
    logic [NREQ-1:0]  d;
    int               lat;
    int               bad;
    int               n_done;
    int               idx;
    logic [NREQ-1:0]  exp_d;
    logic [WIDTH-1:0] exp_w;

    reset    = 1'b1;
    req      = '0;
    req_data = '0;

    // ---------------- Reset state ----------------
    ack_auto = 1'b1;
    ack_rnd  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ch_t", ch_t, 0);
    check("rst_ch_f", ch_f, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err",  err,  0);
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // ---------------- T1: single transfer, req[2] = A5 ----------------
    req_data[2*WIDTH +: WIDTH] = 8'hA5;
    req[2] = 1'b1;
    @(negedge clk);
    check("t1_ch_t", ch_t, 8'hA5);
    check("t1_ch_f", ch_f, 8'h5A);
    check("t1_busy", busy, 1);
    req[2] = 1'b0;  // dropping req mid-transfer must not matter
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (is_spacer(ch_t, ch_f)) begin
        lat = i;
        break;
      end
    end
    check("t1_spacer_lat", lat, 3);
    lat = 0;
    d   = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done != '0) begin
        lat = i;
        d   = done;
        break;
      end
    end
    check("t1_done_lat", lat, 3);
    check("t1_done", d, 4'b0100);
    check("t1_busy_done", busy, 0);
    check("t1_rx", rx_word, 8'hA5);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // ---------------- T2: all four requesting ----------------
    do_reset();
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dat[i];
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      idx   = k % NREQ;
      exp_d = 4'b0001 << idx;
      exp_w = dat[idx];
      wait_done(200, d);
      check($sformatf("t2_grant%0d", k), d, exp_d);
      check($sformatf("t2_rx%0d", k), rx_word, exp_w);
    end
    req = '0;
    repeat (4) @(negedge clk);

    // ---------------- T3: ack high at reset release ----------------
    ack_auto = 1'b0;
    ack_man  = 1'b1;
    @(negedge clk);
    do_reset();
    req_data[1*WIDTH +: WIDTH] = 8'h3C;
    req[1] = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!is_spacer(ch_t, ch_f) || busy) bad++;
    end
    check("t3_no_cw_while_ack", bad, 0);
    ack_man = 1'b0;
    wait_codeword(10, ok);
    check("t3_cw_after_release", ok, 1);
    check("t3_ch_t", ch_t, 8'h3C);
    ack_auto = 1'b1;
    wait_done(100, d);
    check("t3_done", d, 4'b0010);
    req = '0;
    @(negedge clk);

    // ---------------- T4: reset during DATA ----------------
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    do_reset();
    req_data[0 +: WIDTH] = 8'hFF;
    req[0] = 1'b1;
    wait_codeword(10, ok);
    check("t4_cw", ok, 1);
    check("t4_ch_t_ff", ch_t, 8'hFF);
    ack_man = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    check("t4_rst_ch_t", ch_t, 0);
    check("t4_rst_ch_f", ch_f, 0);
    check("t4_rst_busy", busy, 0);
    bad = (done != '0) ? 1 : 0;
    repeat (2) begin
      @(negedge clk);
      if (done != '0) bad++;
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done != '0 || busy || !is_spacer(ch_t, ch_f)) bad++;
    end
    check("t4_no_done_no_grant", bad, 0);
    ack_man = 1'b0;
    wait_codeword(10, ok);
    check("t4_regrant", ok, 1);
    check("t4_regrant_word", ch_t, 8'hFF);
    ack_auto = 1'b1;
    wait_done(100, d);
    check("t4_done", d, 4'b0001);
    req = '0;
    @(negedge clk);

    // ---------------- T5: ack stuck low in DATA (watchdog) ----------------
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    do_reset();
    req_data[3*WIDTH +: WIDTH] = 8'h96;
    req[3] = 1'b1;
    wait_codeword(10, ok);
    check("t5_cw", ok, 1);
    repeat (15) @(negedge clk);
    check("t5_err_before", err, 0);
    @(negedge clk);
`ifdef DRW_TX_TIMEOUT_EN
    check("t5_err_at_limit", err, 1);
`else
    check("t5_err_at_limit", err, 0);
`endif
    repeat (10) @(negedge clk);
`ifdef DRW_TX_TIMEOUT_EN
    check("t5_err_sticky", err, 1);
`else
    check("t5_err_sticky", err, 0);
`endif
    check("t5_cw_held", ch_t, 8'h96);
    check("t5_busy", busy, 1);
    do_reset();
    @(negedge clk);
    check("t5_err_cleared", err, 0);

    // ---------------- T6: random ack delays, 1000 transfers ----------------
    ack_auto = 1'b1;
    ack_rnd  = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      dat[i] = WIDTH'($urandom);
      req_data[i*WIDTH +: WIDTH] = dat[i];
    end
    req    = '1;
    n_done = 0;
    for (int cyc = 0; cyc < 70000 && n_done < 1000; cyc++) begin
      @(negedge clk);
      if (done != '0) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (done[i]) idx = i;
        check("t6_word", rx_word, dat[idx]);
        n_done++;
        if ($urandom_range(0, 3) != 0) begin
          dat[idx] = WIDTH'($urandom);
          req_data[idx*WIDTH +: WIDTH] = dat[idx];
          req[idx] = 1'b1;
        end else begin
          req[idx] = 1'b0;
        end
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            dat[i] = WIDTH'($urandom);
            req_data[i*WIDTH +: WIDTH] = dat[i];
            req[i] = 1'b1;
          end
        end
      end
    end
    check("t6_count", n_done, 1000);

    check("rail_integrity", rail_viol, 0);
    check("done_onehot", done_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
